// File: rtl/rr_stream_mux_pkg.sv
// ==== rr_stream_mux_pkg : shared constants, channel index type, round-robin search ====
// Rev 1.0 -- initial release
`default_nettype none

package rr_stream_mux_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_N     = 8;
  localparam int MAX_N         = 16;
  localparam int CHAN_W        = 4;

  typedef logic [CHAN_W-1:0] chan_t;
  typedef logic [MAX_N-1:0]  req_t;

  typedef struct packed {
    logic  found;
    chan_t idx;
  } pick_t;

  // First set bit of req searching upward from ptr+1, wrapping modulo n.
  function automatic pick_t next_requester(input req_t req, input chan_t ptr, input int n);
    pick_t r;
    int    c;
    chan_t ci;
    r = '0;
    for (int k = 1; k <= MAX_N; k++) begin
      c  = (int'(ptr) + k) % n;
      ci = chan_t'(c);
      if (k <= n && !r.found && req[ci]) begin
        r.found = 1'b1;
        r.idx   = ci;
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_stream_mux_if.sv
// ==== rr_stream_mux_if : N-channel input streams plus one output stream ====
// Rev 1.0 -- initial release
`default_nettype none

interface rr_stream_mux_if #(
  parameter int WIDTH = 16,
  parameter int N     = 8
);
  logic [N*WIDTH-1:0]     in_data;
  logic [N-1:0]           in_valid;
  logic [N-1:0]           in_ready;
  logic [WIDTH-1:0]       out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [$clog2(N)-1:0]   out_chan;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_chan
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_chan
  );
endinterface

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ==== rr_arbiter : combinational round-robin grant with pointer register ====
// Rev 1.0 -- initial release
`default_nettype none

module rr_arbiter
  import rr_stream_mux_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic [N-1:0]         req,
  input  wire logic                 load,
  input  wire logic                 force_en,
  input  wire logic [$clog2(N)-1:0] force_sel,
  output logic      [N-1:0]         grant,
  output logic                      grant_valid,
  output logic      [$clog2(N)-1:0] grant_idx
);

  localparam int CW = $clog2(N);

  logic [CW-1:0] ptr;
  req_t          req_ext;
  pick_t         rr_pick;
  logic          force_hit;

  assign req_ext   = req_t'(req);
  assign rr_pick   = next_requester(req_ext, chan_t'(ptr), N);
  assign force_hit = (int'(force_sel) < N) && req_ext[force_sel];

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant       = '0;
    if (!rst && load) begin
      if (force_en) begin
        if (force_hit) begin
          grant_valid = 1'b1;
          grant_idx   = force_sel;
        end
      end else if (rr_pick.found) begin
        grant_valid = 1'b1;
        grant_idx   = CW'(rr_pick.idx);
      end
    end
    if (grant_valid) begin
      grant = N'(1) << grant_idx;
    end
  end

  // A forced grant leaves the rotation where it was.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= CW'(N - 1);
    end else if (grant_valid && !force_en) begin
      ptr <= grant_idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_stream_mux.sv
// ==== rr_stream_mux : round-robin N-to-1 stream mux with registered output ====
// Rev 1.0 -- optional forced select via RR_STREAM_MUX_FORCE_SEL_EN
`default_nettype none

module rr_stream_mux
  import rr_stream_mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = DEFAULT_N
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
`ifdef RR_STREAM_MUX_FORCE_SEL_EN
  input  wire logic                 force_en,
  input  wire logic [$clog2(N)-1:0] force_sel,
`endif
  rr_stream_mux_if.slave            bus
);

  localparam int CW = $clog2(N);

  logic             load;
  logic             force_en_w;
  logic [CW-1:0]    force_sel_w;
  logic [N-1:0]     grant;
  logic             grant_valid;
  logic [CW-1:0]    grant_idx;
  logic [WIDTH-1:0] data_q;
  logic [CW-1:0]    chan_q;
  logic             valid_q;

`ifdef RR_STREAM_MUX_FORCE_SEL_EN
  assign force_en_w  = force_en;
  assign force_sel_w = force_sel;
`else
  assign force_en_w  = 1'b0;
  assign force_sel_w = '0;
`endif

  assign load = !valid_q || bus.out_ready;

  rr_arbiter #(.N(N)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (bus.in_valid),
    .load        (load),
    .force_en    (force_en_w),
    .force_sel   (force_sel_w),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign bus.in_ready  = grant;
  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;
  assign bus.out_valid = valid_q;

  // Data and channel hold their last value when the slot drains empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
    end else if (grant_valid) begin
      valid_q <= 1'b1;
      data_q  <= bus.in_data[grant_idx*WIDTH +: WIDTH];
      chan_q  <= grant_idx;
    end else if (load) begin
      valid_q <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: doc/rr_stream_mux.md
RR_STREAM_MUX -- requirements
Module: rr_stream_mux

Interface
REQ-001 Parameter WIDTH, default 16: data width per channel in bits.
REQ-002 Parameter N, default 8: number of input channels; legal range 2..16.
REQ-003 Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  reset, synchronous, active-high.
REQ-005 InData  input  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-006 InValid  input  N  channel i has a word offered.
REQ-007 InReady  output  N  channel i word accepted this cycle; one-hot or zero.
REQ-008 OutData  output  WIDTH  registered selected word.
REQ-009 OutValid  output  1  OutData holds a word not yet accepted.
REQ-010 OutReady  input  1  downstream accepts OutData this cycle.
REQ-011 OutChan  output  $clog2(N)  index of the channel that supplied OutData.

Function
REQ-012 Transfer on an input occurs when InValid[i] && InReady[i]; transfer on the output occurs when OutValid && OutReady.
REQ-013 Load condition: Load = !OutValid || OutReady.
REQ-014 When Load is high and any InValid is set, the arbiter grants exactly one channel: the first requester searching upward from Ptr+1 modulo N.
REQ-015 The granted channel sees InReady high in the same cycle; all other InReady bits are low; InReady is all-zero when Load is low.
REQ-016 On a grant, OutData, OutChan and OutValid=1 load on the next edge (latency 1 cycle), and Ptr takes the granted index.
REQ-017 When Load is high with no requester, OutValid clears on the next edge; OutData and OutChan hold their last values.
REQ-018 While OutValid && !OutReady, OutData and OutChan are held stable and no grant is issued.
REQ-019 Sustained throughput is one word per cycle when OutReady is held high.
REQ-020 Ptr wraps from N-1 to 0; a lone requester receives back-to-back grants every cycle.
REQ-021 With all N requesting continuously, grants rotate 0,1,...,N-1,0 after reset; each channel waits at most N-1 grants.
REQ-022 InReady depends combinationally on InValid, OutValid and OutReady only; no combinational path exists from InData to any output.

Reset
REQ-023 On Reset high at an edge: OutValid=0, OutData=0, OutChan=0, Ptr=N-1 (so channel 0 has first priority).
REQ-024 InReady is all-zero while Reset is high.
REQ-025 Reset asserted mid-operation discards any held word without an output transfer.

Configuration
REQ-026 Macro RR_STREAM_MUX_FORCE_SEL_EN, when defined, adds ports Force (input, 1) and ForceSel (input, $clog2(N)).
REQ-027 With the macro defined and Force=1, the grant goes only to channel ForceSel, and only when it is valid; Ptr is not updated.
REQ-028 ForceSel >= N grants nothing.
REQ-029 Without the macro, these ports do not exist and arbitration is always round-robin.

Structure
REQ-030 Package rr_stream_mux_pkg holds: default WIDTH/N constants; a typedef for the channel index; the function returning the next requester given request vector and Ptr.
REQ-031 Sub-module rr_arbiter holds the combinational grant logic and the Ptr register; rr_stream_mux instantiates it and owns the output register.

Verification
REQ-032 Reset, then InValid=8'h00 for 5 cycles -> OutValid=0, InReady=0 throughout.
REQ-033 Channel 3 only valid, data 16'h0003, OutReady=1 -> InReady=8'h08 every cycle; OutData=16'h0003, OutChan=3 from the next cycle onward.
REQ-034 All channels valid, InData word i = 16'h00A0+i, OutReady=1 -> OutChan sequence 0..7,0; OutData follows 16'h00A0..16'h00A7.
REQ-035 Output holding 16'h00A2, OutReady=0 for 4 cycles with all inputs valid -> OutData/OutChan stable; InReady=0 for those cycles; the next grant after release goes to channel 3.
REQ-036 Reset pulsed while OutValid=1 with OutReady=0 -> next cycle OutValid=0, OutData=0; the first subsequent grant with all channels valid goes to channel 0.
REQ-037 With RR_STREAM_MUX_FORCE_SEL_EN defined, Force=1, ForceSel=5 and all channels valid -> OutChan=5 every cycle; after Force drops, the grant goes to channel (previous Ptr+1).
